// File: rtl/aes_encipher_iter.sv
// Iterative AES-128/256 encipher datapath, UNROLL (1 or 2) rounds per clock, external round-key lookup.
// Optional build macro AES_ENC_ZEROIZE_EN: clear the state register on the output handshake and mask block_out when idle.
module aes_encipher_iter #(
   parameter int UNROLL = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    keylen,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [127:0]            block_in,
   output logic [3:0]              round_idx,
   input  logic [128*UNROLL-1:0]   round_key,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [127:0]            block_out,
   output logic                    busy
);

   if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
      $error("aes_encipher_iter: UNROLL must be 1 or 2");
   end

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

   state_t       st;
   logic [127:0] state_q;
   logic [3:0]   rnd;
   logic         keylen_q;
   logic [3:0]   nr;
   logic [127:0] next_state;
   logic         last_step;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte i of the block is row i%4, column i/4; the final round skips MixColumns.
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic final_rnd);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [127:0] r;
      for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++) b[4*c+rr] = a[4*((c+rr)%4)+rr];
      for (int c = 0; c < 4; c++) begin
         if (final_rnd) begin
            r[127-32*c -: 32] = {b[4*c], b[4*c+1], b[4*c+2], b[4*c+3]};
         end else begin
            r[127-32*c -: 8]    = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            r[127-32*c-8 -: 8]  = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            r[127-32*c-16 -: 8] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
            r[127-32*c-24 -: 8] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
         end
      end
      return r ^ k;
   endfunction

   assign nr        = keylen_q ? 4'd14 : 4'd10;
   assign last_step = (rnd + 4'(UNROLL - 1)) == nr;
   assign round_idx = rnd;

   // NOTE: blocking assignments here chain the stages within one cycle; state registers below use <=.
   always_comb begin
      next_state = state_q;
      for (int j = 0; j < UNROLL; j++)
         next_state = aes_round(next_state, round_key[128*j +: 128], (rnd + 4'(j)) == nr);
   end

   // rnd doubles as the round-key index and is held at 0 outside ROUND.
   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= S_IDLE;
         state_q   <= '0;
         rnd       <= '0;
         keylen_q  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (st)
            S_IDLE: begin
               if (in_valid) begin
                  state_q  <= block_in ^ round_key[127:0];
                  keylen_q <= keylen;
                  rnd      <= 4'd1;
                  st       <= S_ROUND;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            S_ROUND: begin
               state_q <= next_state;
               if (last_step) begin
                  rnd       <= '0;
                  st        <= S_DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  rnd <= rnd + 4'(UNROLL);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  st        <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
`ifdef AES_ENC_ZEROIZE_EN
                  state_q   <= '0;
`endif
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

`ifdef AES_ENC_ZEROIZE_EN
   assign block_out = out_valid ? state_q : '0;
`else
   assign block_out = state_q;
`endif

endmodule

// File: tb/tb_aes_encipher_iter.sv
// Self-checking bench for aes_encipher_iter: one UNROLL=1 and one UNROLL=2 instance, FIPS-197 vectors,
// backpressure, mid-run reset and back-to-back blocks; round keys come from a bench key-schedule model.
module tb_aes_encipher_iter;

   logic         clk = 1'b0;
   logic         reset;
   logic         keylen;
   logic [127:0] block_in;
   logic         in_valid  [2];
   logic         out_ready [2];
   logic         in_ready  [2];
   logic         out_valid [2];
   logic         busy      [2];
   logic [3:0]   round_idx [2];
   logic [127:0] block_out [2];
   logic [127:0] rk [16];
   logic [127:0] rk_bus1;
   logic [255:0] rk_bus2;
   logic [7:0]   sb [256];
   int           total = 0;
   int           bad   = 0;

   typedef struct {
      logic [255:0] key;
      logic         kl;
      logic [127:0] pt;
      logic [127:0] ct;
      int           sel;
   } vec_t;

   vec_t vecs [5];

   localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

   always #5 clk = ~clk;

   assign rk_bus1 = rk[round_idx[0]];
   assign rk_bus2 = {rk[round_idx[1] + 4'd1], rk[round_idx[1]]};

   aes_encipher_iter #(.UNROLL(1)) dut1 (
      .clk(clk), .reset(reset), .keylen(keylen),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .block_in(block_in),
      .round_idx(round_idx[0]), .round_key(rk_bus1),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .block_out(block_out[0]),
      .busy(busy[0])
   );

   aes_encipher_iter #(.UNROLL(2)) dut2 (
      .clk(clk), .reset(reset), .keylen(keylen),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .block_in(block_in),
      .round_idx(round_idx[1]), .round_key(rk_bus2),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .block_out(block_out[1]),
      .busy(busy[1])
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box derived from the GF(2^8) inverse and the affine transform.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sb[x] = s;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic load_key(input logic [255:0] key, input logic kl);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      int nk = kl ? 8 : 4;
      int nr = kl ? 14 : 10;
      for (int i = 0; i < 4*(nr+1); i++) begin
         if (i < nk) begin
            w[i] = key[255-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = gf_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
               t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r < 16; r++)
         rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
   endtask

   // Reference cipher using the currently loaded round keys.
   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] v = pt ^ rk[0];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
               v[127-8*(4*c+q) -: 8] = (r == nr) ? t[4*c+q] :
                  gf_mul(t[4*c+q], 8'h02) ^ gf_mul(t[4*c+(q+1)%4], 8'h03)
                  ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
         v = v ^ rk[r];
      end
      return v;
   endfunction

   task automatic run_block(input vec_t v);
      int  s  = v.sel;
      int  u  = v.sel + 1;
      int  nr = v.kl ? 14 : 10;
      int  lat = 0;
      bit  seq_ok = 1'b1;
      load_key(v.key, v.kl);
      check("idle_in_ready", in_ready[s], 1);
      check("idle_round_idx", round_idx[s], 0);
      block_in     = v.pt;
      keylen       = v.kl;
      in_valid[s]  = 1'b1;
      out_ready[s] = 1'b0;
      tick();
      in_valid[s] = 1'b0;
      keylen      = ~v.kl;
      while (out_valid[s] !== 1'b1 && lat < 40) begin
         if (round_idx[s] !== 4'(1 + lat*u) || busy[s] !== 1'b1 || in_ready[s] !== 1'b0) seq_ok = 1'b0;
         tick();
         lat++;
      end
      check("latency", lat, nr/u);
      check("round_idx_seq", seq_ok, 1);
      check("ciphertext", block_out[s], v.ct);
      check("done_busy", busy[s], 0);
      check("done_round_idx", round_idx[s], 0);
      out_ready[s] = 1'b1;
      tick();
      out_ready[s] = 1'b0;
      check("post_out_valid", out_valid[s], 0);
      check("post_in_ready", in_ready[s], 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t         vc1;
      logic [127:0] pts [3];
      logic [127:0] exps [3];
      int           wait_cnt;
      bit           ok;

      build_sbox();
      vecs[0] = '{key: KEY_C1, kl: 1'b0, pt: PT_C, ct: CT_C1, sel: 0};
      vecs[1] = '{key: KEY_C3, kl: 1'b1, pt: PT_C, ct: CT_C3, sel: 1};
      vecs[2] = '{key: KEY_B,  kl: 1'b0, pt: PT_B, ct: CT_B,  sel: 0};
      vecs[3] = '{key: KEY_C1, kl: 1'b0, pt: PT_C, ct: CT_C1, sel: 1};
      vecs[4] = '{key: KEY_C3, kl: 1'b1, pt: PT_C, ct: CT_C3, sel: 0};
      vc1 = vecs[0];

      reset    = 1'b1;
      keylen   = 1'b0;
      block_in = '0;
      for (int s = 0; s < 2; s++) begin
         in_valid[s]  = 1'b0;
         out_ready[s] = 1'b0;
      end
      load_key(KEY_C1, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         check("rst_in_ready", in_ready[s], 1);
         check("rst_out_valid", out_valid[s], 0);
         check("rst_busy", busy[s], 0);
         check("rst_round_idx", round_idx[s], 0);
         check("rst_block_out", block_out[s], 0);
      end

      for (int i = 0; i < 5; i++) run_block(vecs[i]);

      // Backpressure: hold DONE for 20 cycles while pulsing in_valid.
      load_key(KEY_C1, 1'b0);
      block_in    = PT_C;
      keylen      = 1'b0;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      wait_cnt = 0;
      while (out_valid[0] !== 1'b1 && wait_cnt < 40) begin
         tick();
         wait_cnt++;
      end
      check("bp_reach_done", out_valid[0], 1);
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid[0] = 1'(i % 2);
         block_in    = {$urandom, $urandom, $urandom, $urandom};
         tick();
         if (out_valid[0] !== 1'b1 || block_out[0] !== CT_C1 || in_ready[0] !== 1'b0) ok = 1'b0;
      end
      check("bp_stable", ok, 1);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      check("bp_in_ready", in_ready[0], 1);
      check("bp_out_valid", out_valid[0], 0);
`ifdef AES_ENC_ZEROIZE_EN
      check("bp_block_out_after", block_out[0], 128'h0);
`else
      check("bp_block_out_after", block_out[0], CT_C1);
`endif
      ok = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) ok = 1'b0;
      end
      check("bp_pulses_ignored", ok, 1);

      // Reset while round 5 is in progress.
      block_in    = PT_C;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      wait_cnt = 0;
      while (round_idx[0] !== 4'd5 && wait_cnt < 40) begin
         tick();
         wait_cnt++;
      end
      check("mid_reach_round5", round_idx[0], 5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_in_ready", in_ready[0], 1);
      check("mid_rst_out_valid", out_valid[0], 0);
      check("mid_rst_busy", busy[0], 0);
      check("mid_rst_round_idx", round_idx[0], 0);
      check("mid_rst_block_out", block_out[0], 0);
      run_block(vc1);

      // Back-to-back: three blocks, in_valid and out_ready held high, keylen toggled while busy.
      load_key(KEY_C1, 1'b0);
      pts[0]  = PT_C;
      pts[1]  = PT_B;
      pts[2]  = 128'hffeeddccbbaa99887766554433221100;
      exps[0] = CT_C1;
      exps[1] = aes_ref(pts[1], 10);
      exps[2] = aes_ref(pts[2], 10);
      begin
         int n_in = 0;
         int n_out = 0;
         int last_out = 0;
         int cyc = 0;
         bit spacing_ok = 1'b1;
         bit was_ready;
         block_in     = pts[0];
         keylen       = 1'b0;
         in_valid[0]  = 1'b1;
         out_ready[0] = 1'b1;
         while (n_out < 3 && cyc < 100) begin
            was_ready = in_ready[0];
            if (out_valid[0] === 1'b1) begin
               check("b2b_ciphertext", block_out[0], exps[n_out]);
               if (n_out > 0 && cyc - last_out != 12) spacing_ok = 1'b0;
               last_out = cyc;
               n_out++;
            end
            tick();
            cyc++;
            if (was_ready && in_valid[0]) begin
               n_in++;
               if (n_in < 3) block_in = pts[n_in];
               else in_valid[0] = 1'b0;
            end
            keylen = in_ready[0] ? 1'b0 : 1'b1;
         end
         check("b2b_count", n_out, 3);
         check("b2b_spacing", spacing_ok, 1);
         in_valid[0]  = 1'b0;
         out_ready[0] = 1'b0;
      end

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
